mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- MEM pipeline stage of the CPU.
- Sits between the ex_mem pipeline register and the mem_wb pipeline register.
- Issues loads and stores to the memory controller (mem_ctrl) over a level req/done handshake. Holds the pipeline via the stall controller until the access completes.
- Formats load data (byte/half/word, signed/unsigned) and presents the writeback triple (wd, wreg, wdata) plus the op type to mem_wb.

Parameters:
- DATA_W, 32, register/data width.
- OP_W, 4, width of the memory-op code.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active high.
- stall  in  6  pipeline stall vector from the stall controller; bit 3 = MEM stage stop.
- mem_wd_i  in  5  destination register address from ex_mem.
- mem_wreg_i  in  1  register-write enable from ex_mem.
- mem_wdata_i  in  DATA_W  ALU result from ex_mem.
- mem_op_i  in  OP_W  op code: 0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; other values treated as NOP.
- mem_addr_i  in  DATA_W  effective address.
- mem_sdata_i  in  DATA_W  store data (rs2).
- mc_done  in  1  one-cycle pulse from mem_ctrl: access complete.
- mc_rdata  in  DATA_W  load data from mem_ctrl, little-endian from mc_addr, valid with mc_done.
- mc_req  out  1  access request to mem_ctrl, level.
- mc_we  out  1  1 = store.
- mc_addr  out  DATA_W  access address.
- mc_wdata  out  DATA_W  store data, unmodified rs2; mem_ctrl writes the low 1/2/4 bytes.
- mc_width  out  2  0 byte, 1 half, 2 word.
- stallreq_mem  out  1  stall request to the stall controller.
- mem_wd  out  5  destination address to mem_wb.
- mem_wreg  out  1  write enable to mem_wb.
- mem_wdata  out  DATA_W  writeback data to mem_wb.
- memop_type_o  out  OP_W  op code forwarded to mem_wb.

Behaviour:
- FSM states: IDLE, WAIT, HOLD. is_mem = mem_op_i in 1..8.
- IDLE:
  - Non-mem op: outputs pass through from ex_mem combinationally, no request.
  - is_mem: mc_req=1 and stallreq_mem=1 combinationally; next state WAIT.
  - mc_done is ignored in IDLE.
- WAIT:
  - mc_req=1, stallreq_mem=1, mem_wreg=0.
  - mc_addr, mc_we, mc_width and mc_wdata are driven from ex_mem inputs, which the stall keeps stable.
  - On mc_done: latch the formatted result; next state HOLD.
- HOLD:
  - mc_req=0, stallreq_mem=0.
  - Outputs come from latched wd, wreg, result, op.
  - Store: mem_wreg=0, mem_wdata=0.
  - Leave to IDLE when stall[3]=0. Stay in HOLD while stall[3]=1 (stall from another source); no re-issue of the access.
- Load formatting:
  - LB: sign-extend rdata[7:0]; LBU: zero-extend rdata[7:0].
  - LH: sign-extend rdata[15:0]; LHU: zero-extend rdata[15:0].
  - LW: full rdata.
- Latency:
  - Access with mem_ctrl latency L (done in the L-th WAIT cycle): stallreq_mem is high for 1+L cycles; HOLD follows one cycle later.
  - Non-mem ops: 0 added cycles.
- No alignment check; misaligned addresses are forwarded as-is.
- Reset (rst=1 at clk edge): state IDLE; latched registers 0. While rst=1, all outputs are 0, including mc_req and stallreq_mem.
- Reset during WAIT: request is abandoned; mc_req drops in the cycle rst is high. mem_ctrl must tolerate a dropped request.
- memop_type_o: the op in IDLE pass-through and HOLD, 0 in WAIT.

Test Plan:
- Reset: hold rst 2 cycles mid-WAIT → mc_req=0, stallreq_mem=0, all outputs 0; state IDLE after release.
- ALU pass-through: op=0, wd=5, wreg=1, wdata=0x1234 → same values out in the same cycle; stallreq_mem=0; mc_req=0.
- LB sign-extend: addr=0x100, mc_done after 3 WAIT cycles with rdata=0x000000F0 → stallreq_mem high 4 cycles, mc_width=0; HOLD gives wdata=0xFFFFFFF0, wreg=1. LBU with the same data → 0x000000F0.
- LH/LHU/LW: rdata=0xCAFE8001 → LH 0xFFFF8001, LHU 0x00008001, LW 0xCAFE8001; mc_width 1/1/2.
- SW: addr=0x200, sdata=0xDEADBEEF → mc_we=1, mc_width=2, mc_wdata=0xDEADBEEF. On done, HOLD gives mem_wreg=0, memop_type_o=8.
- Hold under external stall: done, then stall[3]=1 for 3 cycles → remains in HOLD, mc_req=0, single access only. Returns to IDLE on the first cycle with stall[3]=0.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage.
//
// Issues loads and stores to the memory controller over a level req/done
// handshake. It holds the pipeline through stallreq_mem until the access
// completes. Loaded data is formatted as byte/half/word, signed or unsigned,
// and the writeback triple plus the op code go on to mem_wb.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset.
//   stall[5:0]          stall vector; bit 3 stops the MEM stage.
//   mem_wd_i, mem_wreg_i, mem_wdata_i
//                       writeback triple from ex_mem.
//   mem_op_i            memory op: 0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU,
//                       6 SB, 7 SH, 8 SW; any other value acts as NOP.
//   mem_addr_i          effective address.
//   mem_sdata_i         store data.
//   mc_done, mc_rdata   completion pulse and load data from mem_ctrl.
//   mc_req, mc_we, mc_addr, mc_wdata, mc_width
//                       access request to mem_ctrl.
//   stallreq_mem        stall request to the stall controller.
//   mem_wd, mem_wreg, mem_wdata, memop_type_o
//                       writeback triple and op code to mem_wb.
module mem_access #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic [4:0]        mem_wd_i,
   input  logic              mem_wreg_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic [OP_W-1:0]   mem_op_i,
   input  logic [DATA_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_sdata_i,
   input  logic              mc_done,
   input  logic [DATA_W-1:0] mc_rdata,
   output logic              mc_req,
   output logic              mc_we,
   output logic [DATA_W-1:0] mc_addr,
   output logic [DATA_W-1:0] mc_wdata,
   output logic [1:0]        mc_width,
   output logic              stallreq_mem,
   output logic [4:0]        mem_wd,
   output logic              mem_wreg,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [OP_W-1:0]   memop_type_o
);

   localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
   localparam logic [OP_W-1:0] OP_LB  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_LH  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_LW  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_LBU = OP_W'(4);
   localparam logic [OP_W-1:0] OP_LHU = OP_W'(5);
   localparam logic [OP_W-1:0] OP_SB  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_SH  = OP_W'(7);
   localparam logic [OP_W-1:0] OP_SW  = OP_W'(8);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [4:0]        wd_r;
   logic              wreg_r;
   logic [DATA_W-1:0] result_r;
   logic [OP_W-1:0]   op_r;

   logic              is_mem_s;
   logic              is_store_s;
   logic [1:0]        width_s;
   logic              unused_stall_s;

   // Only bit 3 of the stall vector concerns this stage.
   assign unused_stall_s = ^{stall[5:4], stall[2:0]};

   // Format load data. Stores produce no writeback value.
   function automatic logic [DATA_W-1:0] fmt_load(input logic [OP_W-1:0] op,
                                                  input logic [DATA_W-1:0] rdata);
      logic [DATA_W-1:0] res;
      case (op)
         OP_LB:   res = {{(DATA_W-8){rdata[7]}}, rdata[7:0]};
         OP_LBU:  res = {{(DATA_W-8){1'b0}}, rdata[7:0]};
         OP_LH:   res = {{(DATA_W-16){rdata[15]}}, rdata[15:0]};
         OP_LHU:  res = {{(DATA_W-16){1'b0}}, rdata[15:0]};
         OP_LW:   res = rdata;
         default: res = {DATA_W{1'b0}};
      endcase
      return res;
   endfunction

   // Decode the op into its access class and width.
   always_comb begin
      is_mem_s   = (mem_op_i >= OP_LB) && (mem_op_i <= OP_SW);
      is_store_s = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
      case (mem_op_i)
         OP_LB, OP_LBU, OP_SB: width_s = 2'd0;
         OP_LH, OP_LHU, OP_SH: width_s = 2'd1;
         OP_LW, OP_SW:         width_s = 2'd2;
         default:              width_s = 2'd0;
      endcase
   end

   // Next-state logic of the access FSM.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (is_mem_s) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (mc_done) begin
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_HOLD: begin
            // Another stall source keeps ex_mem frozen. Stay put and do not
            // issue the same access again.
            if (stall[3]) begin
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register, plus the result captured when mem_ctrl completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         wd_r     <= 5'd0;
         wreg_r   <= 1'b0;
         result_r <= {DATA_W{1'b0}};
         op_r     <= OP_NOP;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == ST_WAIT) && mc_done) begin
            wd_r     <= mem_wd_i;
            wreg_r   <= mem_wreg_i & ~is_store_s;
            result_r <= fmt_load(mem_op_i, mc_rdata);
            op_r     <= mem_op_i;
         end
      end
   end

   // Output decode. While rst is high, every output stays at zero.
   always_comb begin
      mc_req       = 1'b0;
      mc_we        = 1'b0;
      mc_addr      = {DATA_W{1'b0}};
      mc_wdata     = {DATA_W{1'b0}};
      mc_width     = 2'd0;
      stallreq_mem = 1'b0;
      mem_wd       = 5'd0;
      mem_wreg     = 1'b0;
      mem_wdata    = {DATA_W{1'b0}};
      memop_type_o = OP_NOP;
      if (!rst) begin
         case (state_r)
            ST_IDLE: begin
               memop_type_o = mem_op_i;
               mem_wd       = mem_wd_i;
               if (is_mem_s) begin
                  // Request goes out in the same cycle to save a stall cycle.
                  mc_req       = 1'b1;
                  stallreq_mem = 1'b1;
                  mc_we        = is_store_s;
                  mc_addr      = mem_addr_i;
                  mc_wdata     = mem_sdata_i;
                  mc_width     = width_s;
               end else begin
                  mem_wreg  = mem_wreg_i;
                  mem_wdata = mem_wdata_i;
               end
            end
            ST_WAIT: begin
               // The stall keeps the ex_mem inputs stable, so drive from them.
               mc_req       = 1'b1;
               stallreq_mem = 1'b1;
               mc_we        = is_store_s;
               mc_addr      = mem_addr_i;
               mc_wdata     = mem_sdata_i;
               mc_width     = width_s;
            end
            ST_HOLD: begin
               mem_wd       = wd_r;
               mem_wreg     = wreg_r;
               mem_wdata    = result_r;
               memop_type_o = op_r;
            end
            default: begin
               mc_req = 1'b0;
            end
         endcase
      end else begin
         mc_req = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed bench for the MEM stage. A model of mem_ctrl
// returns done after a chosen number of WAIT cycles. Each expected value
// is written out by hand.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic [4:0]  mem_wd_i;
   logic        mem_wreg_i;
   logic [31:0] mem_wdata_i;
   logic [3:0]  mem_op_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_sdata_i;
   logic        mc_done;
   logic [31:0] mc_rdata;
   logic        mc_req;
   logic        mc_we;
   logic [31:0] mc_addr;
   logic [31:0] mc_wdata;
   logic [1:0]  mc_width;
   logic        stallreq_mem;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic [3:0]  memop_type_o;

   int total_cnt = 0;
   int bad_cnt   = 0;

   mem_access #(.DATA_W(32), .OP_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .mem_wd_i     (mem_wd_i),
      .mem_wreg_i   (mem_wreg_i),
      .mem_wdata_i  (mem_wdata_i),
      .mem_op_i     (mem_op_i),
      .mem_addr_i   (mem_addr_i),
      .mem_sdata_i  (mem_sdata_i),
      .mc_done      (mc_done),
      .mc_rdata     (mc_rdata),
      .mc_req       (mc_req),
      .mc_we        (mc_we),
      .mc_addr      (mc_addr),
      .mc_wdata     (mc_wdata),
      .mc_width     (mc_width),
      .stallreq_mem (stallreq_mem),
      .mem_wd       (mem_wd),
      .mem_wreg     (mem_wreg),
      .mem_wdata    (mem_wdata),
      .memop_type_o (memop_type_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   // Move to 1 ns after the next rising edge. Inputs change here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic [31:0] addr,
                         input logic [31:0] sdata);
      mem_op_i    = op;
      mem_wd_i    = wd;
      mem_wreg_i  = wreg;
      mem_wdata_i = wdata;
      mem_addr_i  = addr;
      mem_sdata_i = sdata;
   endtask

   // Run one access. The first cycle is IDLE with the request out. Then
   // come lat WAIT cycles, with done in the last one. Then HOLD, which
   // lasts hold_cyc extra cycles under an external stall[3]. A NOP follows
   // to confirm the return to IDLE.
   task automatic run_mem(input string nm, input logic [3:0] op, input logic [4:0] wd,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int lat, input int hold_cyc,
                          input logic [31:0] exp_wdata, input logic exp_wreg,
                          input logic [1:0] exp_width, input logic exp_we);
      int stall_cnt;
      int req_cnt;
      tick();
      set_in(op, wd, 1'b1, addr, addr, sdata);
      stall   = 6'b000000;
      mc_done = 1'b0;
      #1;
      chk({nm, "_req"},   {31'd0, mc_req},   32'd1);
      chk({nm, "_width"}, {30'd0, mc_width}, {30'd0, exp_width});
      chk({nm, "_we"},    {31'd0, mc_we},    {31'd0, exp_we});
      chk({nm, "_addr"},  mc_addr,           addr);
      chk({nm, "_wdat"},  mc_wdata,          sdata);
      stall_cnt = int'(stallreq_mem);
      for (int k = 1; k <= lat; k++) begin
         tick();
         mc_done  = (k == lat);
         mc_rdata = (k == lat) ? rdata : 32'h0BAD_0BAD;
         #1;
         stall_cnt += int'(stallreq_mem);
         if (k == 1) begin
            chk({nm, "_wait_wreg"}, {31'd0, mem_wreg},  32'd0);
            chk({nm, "_wait_op"},   {28'd0, memop_type_o}, 32'd0);
            chk({nm, "_wait_req"},  {31'd0, mc_req},    32'd1);
         end
      end
      tick();
      mc_done  = 1'b0;
      mc_rdata = 32'h0;
      stall    = (hold_cyc > 0) ? 6'b001000 : 6'b000000;
      #1;
      chk({nm, "_stall_cyc"}, 32'(stall_cnt), 32'(1 + lat));
      chk({nm, "_hold_sreq"}, {31'd0, stallreq_mem}, 32'd0);
      chk({nm, "_hold_req"},  {31'd0, mc_req},       32'd0);
      chk({nm, "_hold_wdata"}, mem_wdata,            exp_wdata);
      chk({nm, "_hold_wreg"}, {31'd0, mem_wreg},     {31'd0, exp_wreg});
      chk({nm, "_hold_op"},   {28'd0, memop_type_o}, {28'd0, op});
      chk({nm, "_hold_wd"},   {27'd0, mem_wd},       {27'd0, wd});
      req_cnt = 0;
      for (int h = 1; h <= hold_cyc; h++) begin
         tick();
         stall = (h < hold_cyc) ? 6'b001000 : 6'b000000;
         #1;
         req_cnt += int'(mc_req);
         chk({nm, "_held_wdata"}, mem_wdata, exp_wdata);
      end
      if (hold_cyc > 0) begin
         chk({nm, "_no_reissue"}, 32'(req_cnt), 32'd0);
      end
      // ex_mem advances to a NOP. Pass-through shows the FSM is back in IDLE.
      tick();
      stall = 6'b000000;
      set_in(4'd0, 5'd9, 1'b1, 32'h55AA_1234, 32'h0, 32'h0);
      #1;
      chk({nm, "_idle_wdata"}, mem_wdata,             32'h55AA_1234);
      chk({nm, "_idle_sreq"},  {31'd0, stallreq_mem}, 32'd0);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_req"},   {31'd0, mc_req},       32'd0);
      chk({nm, "_sreq"},  {31'd0, stallreq_mem}, 32'd0);
      chk({nm, "_wdata"}, mem_wdata,             32'd0);
      chk({nm, "_wreg"},  {31'd0, mem_wreg},     32'd0);
      chk({nm, "_wd"},    {27'd0, mem_wd},       32'd0);
      chk({nm, "_op"},    {28'd0, memop_type_o}, 32'd0);
      chk({nm, "_addr"},  mc_addr,               32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      stall    = 6'b000000;
      mc_done  = 1'b0;
      mc_rdata = 32'h0;
      set_in(4'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);

      // Power-on reset, with a LW on the inputs to show the outputs are gated.
      tick();
      set_in(4'd3, 5'd4, 1'b1, 32'h1111_2222, 32'h0000_0040, 32'h0);
      #1;
      chk_zero("por");
      tick();
      rst = 1'b0;
      set_in(4'd0, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0);
      #1;

      // ALU pass-through.
      chk("alu_wd",    {27'd0, mem_wd},       32'd5);
      chk("alu_wreg",  {31'd0, mem_wreg},     32'd1);
      chk("alu_wdata", mem_wdata,             32'h0000_1234);
      chk("alu_sreq",  {31'd0, stallreq_mem}, 32'd0);
      chk("alu_req",   {31'd0, mc_req},       32'd0);

      // Reset in the middle of WAIT.
      tick();
      set_in(4'd3, 5'd6, 1'b1, 32'h0000_0080, 32'h0000_0080, 32'h0);
      #1;
      tick();
      #1;
      chk("rw_wait_req", {31'd0, mc_req}, 32'd1);
      tick();
      rst = 1'b1;
      #1;
      chk_zero("rw_rst1");
      tick();
      #1;
      chk_zero("rw_rst2");
      tick();
      rst = 1'b0;
      #1;
      // Still a LW on the inputs. IDLE forwards op 3, while WAIT would show 0.
      chk("rw_idle_op",  {28'd0, memop_type_o}, 32'd3);
      chk("rw_idle_req", {31'd0, mc_req},       32'd1);
      set_in(4'd0, 5'd1, 1'b0, 32'h0, 32'h0, 32'h0);
      #1;
      chk("rw_nop_sreq", {31'd0, stallreq_mem}, 32'd0);

      //       name   op    wd    addr          sdata         rdata         lat hold exp_wdata     wreg  width we
      run_mem("lb",  4'd1, 5'd3, 32'h0000_0100, 32'h0,        32'h0000_00F0, 3, 0, 32'hFFFF_FFF0, 1'b1, 2'd0, 1'b0);
      run_mem("lbu", 4'd4, 5'd3, 32'h0000_0100, 32'h0,        32'h0000_00F0, 3, 0, 32'h0000_00F0, 1'b1, 2'd0, 1'b0);
      run_mem("lh",  4'd2, 5'd8, 32'h0000_0104, 32'h0,        32'hCAFE_8001, 1, 0, 32'hFFFF_8001, 1'b1, 2'd1, 1'b0);
      run_mem("lhu", 4'd5, 5'd8, 32'h0000_0106, 32'h0,        32'hCAFE_8001, 2, 0, 32'h0000_8001, 1'b1, 2'd1, 1'b0);
      run_mem("lw",  4'd3, 5'd8, 32'h0000_0108, 32'h0,        32'hCAFE_8001, 1, 0, 32'hCAFE_8001, 1'b1, 2'd2, 1'b0);
      run_mem("sw",  4'd8, 5'd2, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0,        2, 0, 32'h0,         1'b0, 2'd2, 1'b1);
      run_mem("sb",  4'd6, 5'd2, 32'h0000_0203, 32'h1122_3344, 32'h0,        1, 0, 32'h0,         1'b0, 2'd0, 1'b1);
      run_mem("hold",4'd3, 5'd17,32'h0000_0300, 32'h0,        32'h1357_2468, 1, 3, 32'h1357_2468, 1'b1, 2'd2, 1'b0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
